// File: rtl/ulpb_rx_dispatch.sv
// ulpb_rx_dispatch
// Sits between a ulpb_node32 RX port and the local layer (CLK_EXT domain).
// Each received message is compared against NUM_CTRL masked control addresses:
// matching messages are acked locally and queued for the control logic, all
// others are forwarded to the user RX port with the same 4-phase REQ/ACK
// handshake.
// Build option: define ULPB_RXD_BACKPRESSURE_EN to withhold the node ack while
// the control FIFO is full (no drops, OVERFLOW tied low). Without it a control
// message arriving at a full FIFO is acked, discarded and flagged in OVERFLOW.
module ulpb_rx_dispatch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CTRL   = 2,
  parameter logic [NUM_CTRL*ADDR_WIDTH-1:0] CTRL_ADDRS = {8'h01, 8'h02},
  parameter logic [NUM_CTRL*ADDR_WIDTH-1:0] CTRL_MASKS = {8'hff, 8'hff},
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2,
  parameter int IDX_W      = 1
) (
  input  logic                  CLK_EXT,
  input  logic                  RESETn,
  input  logic [ADDR_WIDTH-1:0] NODE_RX_ADDR,
  input  logic [DATA_WIDTH-1:0] NODE_RX_DATA,
  input  logic                  NODE_RX_REQ,
  output logic                  NODE_RX_ACK,
  output logic [ADDR_WIDTH-1:0] RX_ADDR,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_REQ,
  input  logic                  RX_ACK,
  input  logic [NUM_CTRL-1:0]   CTRL_EN,
  output logic                  CTRL_VALID,
  input  logic                  CTRL_RD,
  output logic [ADDR_WIDTH-1:0] CTRL_ADDR,
  output logic [DATA_WIDTH-1:0] CTRL_DATA,
  output logic [IDX_W-1:0]      CTRL_IDX,
  output logic [PTR_W:0]        FIFO_LEVEL,
  output logic                  OVERFLOW,
  input  logic                  OVF_CLR
);

  localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH + IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_USER,
    S_WAIT_ACK,
    S_CAPTURE,
    S_WAIT_LOW
  } state_t;

  state_t                  state_reg;
  logic                    req_meta_reg;
  logic                    req_s_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic                    node_ack_reg;
  logic                    rx_req_reg;
  logic [ADDR_WIDTH-1:0]   rx_addr_reg;
  logic [DATA_WIDTH-1:0]   rx_data_reg;

  logic [NUM_CTRL-1:0]     ch_match;
  logic                    any_match;
  logic [IDX_W-1:0]        match_idx;

  logic [ENT_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [PTR_W:0]          level_reg;
  logic [ENT_W-1:0]        head;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    pop;
  logic                    push;

  // Per-channel masked address compare; a disabled channel never matches.
  for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_match
    assign ch_match[gi] = CTRL_EN[gi] &&
      (((NODE_RX_ADDR ^ CTRL_ADDRS[gi*ADDR_WIDTH +: ADDR_WIDTH]) &
        CTRL_MASKS[gi*ADDR_WIDTH +: ADDR_WIDTH]) == '0);
  end

  // Priority encode: the lowest matching channel wins.
  always_comb begin
    any_match = |ch_match;
    match_idx = '0;
    for (int i = NUM_CTRL - 1; i >= 0; i--) begin
      if (ch_match[i]) match_idx = IDX_W'(i);
    end
  end

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop        = CTRL_RD && !fifo_empty;
  // A pop in the same cycle frees the slot the capture needs.
  assign push       = (state_reg == S_CAPTURE) && (!fifo_full || pop);

  // Two-flop synchroniser for the node request, which is asynchronous to CLK_EXT.
  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) begin
      req_meta_reg <= 1'b0;
      req_s_reg    <= 1'b0;
    end else begin
      req_meta_reg <= NODE_RX_REQ;
      req_s_reg    <= req_meta_reg;
    end
  end

  // Handshake FSM: classify, forward to user or capture into the FIFO.
  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      data_reg     <= '0;
      idx_reg      <= '0;
      node_ack_reg <= 1'b0;
      rx_req_reg   <= 1'b0;
      rx_addr_reg  <= '0;
      rx_data_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_s_reg) begin
            addr_reg <= NODE_RX_ADDR;
            data_reg <= NODE_RX_DATA;
            idx_reg  <= match_idx;
            if (any_match) begin
              state_reg <= S_CAPTURE;
            end else begin
              rx_addr_reg <= NODE_RX_ADDR;
              rx_data_reg <= NODE_RX_DATA;
              rx_req_reg  <= 1'b1;
              state_reg   <= S_USER;
            end
          end
        end
        S_USER: begin
          node_ack_reg <= RX_ACK;
          if (!req_s_reg && RX_ACK) begin
            rx_req_reg <= 1'b0;
            state_reg  <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          node_ack_reg <= RX_ACK;
          if (!RX_ACK) state_reg <= S_IDLE;
        end
        S_CAPTURE: begin
`ifdef ULPB_RXD_BACKPRESSURE_EN
          // Hold off the node until a slot is available.
          if (push) begin
            node_ack_reg <= 1'b1;
            state_reg    <= S_WAIT_LOW;
          end
`else
          // Always ack; a full FIFO discards the message (see overflow flag).
          node_ack_reg <= 1'b1;
          state_reg    <= S_WAIT_LOW;
`endif
        end
        S_WAIT_LOW: begin
          if (!req_s_reg) begin
            node_ack_reg <= 1'b0;
            state_reg    <= S_IDLE;
          end
        end
        default: begin
          node_ack_reg <= 1'b0;
          rx_req_reg   <= 1'b0;
          state_reg    <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO storage write; contents need no reset because the pointers gate them.
  always_ff @(posedge CLK_EXT) begin
    if (push) mem[wr_ptr_reg] <= {addr_reg, data_reg, idx_reg};
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the level.
  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

`ifdef ULPB_RXD_BACKPRESSURE_EN
  logic ovf_clr_unused;
  assign ovf_clr_unused = OVF_CLR;
  assign OVERFLOW       = 1'b0;
`else
  logic overflow_reg;
  logic drop;
  assign drop = (state_reg == S_CAPTURE) && !push;

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn)      overflow_reg <= 1'b0;
    else if (drop)    overflow_reg <= 1'b1;
    else if (OVF_CLR) overflow_reg <= 1'b0;
  end
  assign OVERFLOW = overflow_reg;
`endif

  // Head entry is read straight from storage and forced to zero when empty.
  assign head       = mem[rd_ptr_reg];
  assign CTRL_VALID = !fifo_empty;
  assign CTRL_ADDR  = fifo_empty ? '0 : head[IDX_W+DATA_WIDTH +: ADDR_WIDTH];
  assign CTRL_DATA  = fifo_empty ? '0 : head[IDX_W +: DATA_WIDTH];
  assign CTRL_IDX   = fifo_empty ? '0 : head[IDX_W-1:0];
  assign FIFO_LEVEL = level_reg;

  assign NODE_RX_ACK = node_ack_reg;
  assign RX_REQ      = rx_req_reg;
  assign RX_ADDR     = rx_addr_reg;
  assign RX_DATA     = rx_data_reg;

endmodule

// File: tb/tb_ulpb_rx_dispatch.sv
// tb_ulpb_rx_dispatch
// Randomised and directed stimulus for ulpb_rx_dispatch checked against a
// queue-based reference model. Honours ULPB_RXD_BACKPRESSURE_EN if defined.
module tb_ulpb_rx_dispatch;

  localparam int NC    = 2;
  localparam int DEPTH = 4;

  logic        CLK_EXT = 1'b0;
  logic        RESETn  = 1'b0;
  logic [7:0]  NODE_RX_ADDR = '0;
  logic [31:0] NODE_RX_DATA = '0;
  logic        NODE_RX_REQ  = 1'b0;
  logic        NODE_RX_ACK;
  logic [7:0]  RX_ADDR;
  logic [31:0] RX_DATA;
  logic        RX_REQ;
  logic        RX_ACK  = 1'b0;
  logic [1:0]  CTRL_EN = 2'b11;
  logic        CTRL_VALID;
  logic        CTRL_RD = 1'b0;
  logic [7:0]  CTRL_ADDR;
  logic [31:0] CTRL_DATA;
  logic [0:0]  CTRL_IDX;
  logic [2:0]  FIFO_LEVEL;
  logic        OVERFLOW;
  logic        OVF_CLR = 1'b0;

  ulpb_rx_dispatch #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .NUM_CTRL   (2),
    .CTRL_ADDRS ({8'h20, 8'h01}),
    .CTRL_MASKS ({8'hf0, 8'hff}),
    .FIFO_DEPTH (4),
    .PTR_W      (2),
    .IDX_W      (1)
  ) dut (
    .CLK_EXT      (CLK_EXT),
    .RESETn       (RESETn),
    .NODE_RX_ADDR (NODE_RX_ADDR),
    .NODE_RX_DATA (NODE_RX_DATA),
    .NODE_RX_REQ  (NODE_RX_REQ),
    .NODE_RX_ACK  (NODE_RX_ACK),
    .RX_ADDR      (RX_ADDR),
    .RX_DATA      (RX_DATA),
    .RX_REQ       (RX_REQ),
    .RX_ACK       (RX_ACK),
    .CTRL_EN      (CTRL_EN),
    .CTRL_VALID   (CTRL_VALID),
    .CTRL_RD      (CTRL_RD),
    .CTRL_ADDR    (CTRL_ADDR),
    .CTRL_DATA    (CTRL_DATA),
    .CTRL_IDX     (CTRL_IDX),
    .FIFO_LEVEL   (FIFO_LEVEL),
    .OVERFLOW     (OVERFLOW),
    .OVF_CLR      (OVF_CLR)
  );

  always #5 CLK_EXT = ~CLK_EXT;

  int checks = 0;
  int errors = 0;

  // Reference model: control channel table, queued entries, sticky flag.
  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    int          idx;
  } ent_t;

  ent_t       q[$];
  logic       ovf_m = 1'b0;
  logic [7:0] ref_addr [NC] = '{8'h01, 8'h20};
  logic [7:0] ref_mask [NC] = '{8'hff, 8'hf0};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns the winning channel, or -1 for a user message.
  function automatic int ref_match(input logic [7:0] a, input logic [1:0] en);
    for (int c = 0; c < NC; c++) begin
      if (en[c] && ((a & ref_mask[c]) == (ref_addr[c] & ref_mask[c]))) return c;
    end
    return -1;
  endfunction

  task automatic check_head(input string tag);
    check_eq({tag, "_level"}, 64'(FIFO_LEVEL), 64'(q.size()));
    check_eq({tag, "_valid"}, 64'(CTRL_VALID), 64'(q.size() != 0));
    check_eq({tag, "_ovf"}, 64'(OVERFLOW), 64'(ovf_m));
    if (q.size() != 0) begin
      check_eq({tag, "_addr"}, 64'(CTRL_ADDR), 64'(q[0].a));
      check_eq({tag, "_data"}, 64'(CTRL_DATA), 64'(q[0].d));
      check_eq({tag, "_idx"}, 64'(CTRL_IDX), 64'(q[0].idx));
    end
  endtask

  // Bounded wait: sel 0 = NODE_RX_ACK, sel 1 = RX_REQ. Returns negedges waited.
  task automatic wait_for(input int sel, input logic lvl, output int cyc);
    logic s;
    cyc = 0;
    s = (sel == 0) ? NODE_RX_ACK : RX_REQ;
    while (cyc < 40 && s !== lvl) begin
      @(negedge CLK_EXT);
      cyc++;
      s = (sel == 0) ? NODE_RX_ACK : RX_REQ;
    end
    if (cyc >= 40) check_eq((sel == 0) ? "ack_timeout" : "rxreq_timeout", 64'(s), 64'(lvl));
  endtask

  task automatic pop_one();
    check_head("pre_pop");
    CTRL_RD = 1'b1;
    @(negedge CLK_EXT);
    CTRL_RD = 1'b0;
    if (q.size() != 0) q.delete(0);
    check_head("post_pop");
    $display("pop  level=%0d", q.size());
  endtask

  // One full node transaction; called at a negedge with NODE_RX_REQ low.
  task automatic send(input logic [7:0] a, input logic [31:0] d, input bit rd_cap, input bit clr_cap);
    int   m;
    int   cyc;
    bit   full;
    ent_t e;
    m = ref_match(a, CTRL_EN);
    NODE_RX_ADDR = a;
    NODE_RX_DATA = d;
    NODE_RX_REQ  = 1'b1;
    if (m >= 0) begin
      repeat (3) @(negedge CLK_EXT);
      check_eq("ctrl_early_ack", 64'(NODE_RX_ACK), 64'(0));
      if (rd_cap) begin
        check_head("cap_pre_pop");
        CTRL_RD = 1'b1;
        if (q.size() != 0) q.delete(0);
      end
      OVF_CLR = clr_cap;
      @(negedge CLK_EXT);
      CTRL_RD = 1'b0;
      OVF_CLR = 1'b0;
      e.a = a; e.d = d; e.idx = m;
      full = (q.size() >= DEPTH);
`ifdef ULPB_RXD_BACKPRESSURE_EN
      if (full) begin
        check_eq("bp_ack_withheld", 64'(NODE_RX_ACK), 64'(0));
        repeat (5) @(negedge CLK_EXT);
        check_eq("bp_ack_still_withheld", 64'(NODE_RX_ACK), 64'(0));
        check_head("bp_stall");
        CTRL_RD = 1'b1;
        @(negedge CLK_EXT);
        CTRL_RD = 1'b0;
        q.delete(0);
      end
      q.push_back(e);
`else
      if (full) begin
        ovf_m = 1'b1;
      end else begin
        q.push_back(e);
        if (clr_cap) ovf_m = 1'b0;
      end
`endif
      check_eq("ctrl_ack", 64'(NODE_RX_ACK), 64'(1));
      check_eq("ctrl_no_user_req", 64'(RX_REQ), 64'(0));
      check_head("ctrl_push");
      NODE_RX_REQ = 1'b0;
      wait_for(0, 1'b0, cyc);
      check_eq("ctrl_ack_release", 64'(cyc), 64'(3));
      $display("ctrl addr=%02h data=%08h idx=%0d level=%0d ovf=%0d", a, d, m, q.size(), ovf_m);
    end else begin
      wait_for(1, 1'b1, cyc);
      check_eq("user_req_latency", 64'(cyc), 64'(3));
      check_eq("user_addr", 64'(RX_ADDR), 64'(a));
      check_eq("user_data", 64'(RX_DATA), 64'(d));
      check_eq("user_ack_before_rxack", 64'(NODE_RX_ACK), 64'(0));
      repeat ($urandom_range(0, 3)) @(negedge CLK_EXT);
      check_eq("user_req_held", 64'(RX_REQ), 64'(1));
      RX_ACK = 1'b1;
      wait_for(0, 1'b1, cyc);
      check_eq("user_ack_follow", 64'(cyc), 64'(1));
      NODE_RX_REQ = 1'b0;
      wait_for(1, 1'b0, cyc);
      check_eq("user_req_fall", 64'(cyc), 64'(3));
      check_eq("user_ack_held", 64'(NODE_RX_ACK), 64'(1));
      RX_ACK = 1'b0;
      wait_for(0, 1'b0, cyc);
      check_eq("user_ack_release", 64'(cyc), 64'(1));
      check_head("user_fifo");
      $display("user addr=%02h data=%08h en=%b", a, d, CTRL_EN);
    end
  endtask

  initial begin
    int         cyc;
    logic [7:0] a;

    // Reset state
    repeat (2) @(negedge CLK_EXT);
    check_eq("rst_node_ack", 64'(NODE_RX_ACK), 64'(0));
    check_eq("rst_rx_req", 64'(RX_REQ), 64'(0));
    check_eq("rst_rx_addr", 64'(RX_ADDR), 64'(0));
    check_eq("rst_rx_data", 64'(RX_DATA), 64'(0));
    check_eq("rst_ctrl_addr", 64'(CTRL_ADDR), 64'(0));
    check_eq("rst_ctrl_data", 64'(CTRL_DATA), 64'(0));
    check_eq("rst_ctrl_idx", 64'(CTRL_IDX), 64'(0));
    check_head("rst");
    RESETn = 1'b1;
    @(negedge CLK_EXT);
    check_head("post_rst");

    // Control message, then user message, then masked channel 1
    send(8'h01, 32'hDEADBEEF, 1'b0, 1'b0);
    send(8'haa, 32'h12345678, 1'b0, 1'b0);
    send(8'h2f, 32'hCAFEF00D, 1'b0, 1'b0);
    CTRL_EN = 2'b01;
    send(8'h2f, 32'h0BADF00D, 1'b0, 1'b0);
    CTRL_EN = 2'b11;
    while (q.size() != 0) pop_one();
    pop_one();

    // Fill the FIFO, then one more
    for (int i = 0; i < 5; i++) send((i % 2) ? 8'h01 : 8'h23, $urandom, 1'b0, 1'b0);
    OVF_CLR = 1'b1;
    @(negedge CLK_EXT);
    OVF_CLR = 1'b0;
    ovf_m = 1'b0;
    check_head("ovf_clr");
    // Clear coinciding with a drop
    send(8'h01, 32'h55AA55AA, 1'b0, 1'b1);
    OVF_CLR = 1'b1;
    @(negedge CLK_EXT);
    OVF_CLR = 1'b0;
    ovf_m = 1'b0;
    check_head("ovf_clr2");

    // Full FIFO with a pop in the capture cycle
    send(8'h2c, 32'hA5A5A5A5, 1'b1, 1'b0);

    // Reset while in WAIT_LOW with two entries queued
    while (q.size() != 0) pop_one();
    send(8'h01, 32'h11111111, 1'b0, 1'b0);
    send(8'h21, 32'h22222222, 1'b0, 1'b0);
    NODE_RX_ADDR = 8'h01;
    NODE_RX_DATA = 32'h33333333;
    NODE_RX_REQ  = 1'b1;
    wait_for(0, 1'b1, cyc);
    check_eq("mid_ack_latency", 64'(cyc), 64'(4));
    #2 RESETn = 1'b0;
    #1;
    q.delete();
    ovf_m = 1'b0;
    check_eq("mid_rst_ack", 64'(NODE_RX_ACK), 64'(0));
    check_head("mid_rst");
    NODE_RX_REQ = 1'b0;
    repeat (2) @(negedge CLK_EXT);
    RESETn = 1'b1;
    @(negedge CLK_EXT);
    check_head("after_mid_rst");
    $display("reset mid-handshake level=%0d", q.size());
    send(8'haa, 32'h44444444, 1'b0, 1'b0);
    send(8'h01, 32'h55555555, 1'b0, 1'b0);

    // Randomised traffic
    for (int it = 0; it < 60; it++) begin
      CTRL_EN = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       a = 8'h01;
        1:       a = {4'h2, 4'($urandom)};
        2:       a = 8'h02;
        default: a = 8'($urandom);
      endcase
      if (q.size() >= DEPTH || $urandom_range(0, 3) == 0) pop_one();
      send(a, $urandom, ($urandom_range(0, 4) == 0), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
